acq_sequencer: RTL

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

---
 rtl/acq_sequencer_if.sv | 27 ++
 rtl/acq_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer_if.sv
// Command/status bundle between the acquisition host, the sequencer and the readout controller.
// The driver side uses the master modport; the sequencer uses slave.
interface acq_sequencer_if #(
   parameter int unsigned CMD_WIDTH   = 16,
   parameter int unsigned COUNT_WIDTH = 32,
   parameter int unsigned FRAME_WIDTH = 16
);
   logic [CMD_WIDTH-1:0]   cmd;
   logic                   cmd_valid;
   logic                   frame_done;
   logic                   cmd_ready;
   logic                   running;
   logic [COUNT_WIDTH-1:0] integration_clock_count;
   logic [FRAME_WIDTH-1:0] frame_count;
   logic                   burst_done;
   logic                   cmd_error;

   modport master (
      output cmd, cmd_valid, frame_done,
      input  cmd_ready, running, integration_clock_count, frame_count, burst_done, cmd_error
   );

   modport slave (
      input  cmd, cmd_valid, frame_done,
      output cmd_ready, running, integration_clock_count, frame_count, burst_done, cmd_error
   );
endinterface

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: decodes host commands into continuous or burst readout runs and
// tracks the integration length and frame count, with all outputs registered.
module acq_sequencer #(
   parameter int unsigned CMD_WIDTH    = 16,
   parameter int unsigned COUNT_WIDTH  = 32,
   parameter int unsigned INTG_SHIFT   = 2,
   parameter int unsigned FRAME_WIDTH  = 16,
   parameter int unsigned DEFAULT_INTG = 5000
) (
   input logic            clk_in,
   input logic            reset_n,
   acq_sequencer_if.slave bus
);
   localparam int unsigned VAL_WIDTH  = CMD_WIDTH - 2;
   localparam int unsigned WIDE_WIDTH = COUNT_WIDTH + VAL_WIDTH;

   typedef enum logic [1:0] {StIdle, StRunCont, StRunBurst, StStopping} state_e;
   typedef enum logic [1:0] {
      OpNoop   = 2'b00,
      OpStart  = 2'b01,
      OpStop   = 2'b10,
      OpSingle = 2'b11
   } op_e;

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [COUNT_WIDTH-1:0] pend_q, pend_d;
   logic                   pend_valid_q, pend_valid_d;
   logic [VAL_WIDTH-1:0]   remaining_q, remaining_d;
   logic [FRAME_WIDTH-1:0] frames_q, frames_d;
   logic                   burst_done_q, burst_done_d;
   logic                   cmd_error_q, cmd_error_d;
   logic                   running_q, cmd_ready_q;

   op_e                    op;
   logic [VAL_WIDTH-1:0]   val;
   logic [WIDE_WIDTH-1:0]  wide_count;
   logic [COUNT_WIDTH-1:0] new_count;

   assign op  = op_e'(bus.cmd[CMD_WIDTH-1 -: 2]);
   assign val = bus.cmd[VAL_WIDTH-1:0];

   // Widen before shifting so truncation happens only at COUNT_WIDTH.
   assign wide_count = {{COUNT_WIDTH{1'b0}}, val} << INTG_SHIFT;
   assign new_count  = wide_count[COUNT_WIDTH-1:0];

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      remaining_d  = remaining_q;
      frames_d     = frames_q;
      burst_done_d = 1'b0;
      cmd_error_d  = 1'b0;

      // End of frame is resolved first; a same-cycle command sees the resulting state.
      if (bus.frame_done && (state_q != StIdle)) begin
         frames_d = frames_q + FRAME_WIDTH'(1);
         case (state_q)
            StRunCont, StRunBurst: begin
               if (pend_valid_q) begin
                  count_d      = pend_q;
                  pend_valid_d = 1'b0;
                  state_d      = StRunCont;
               end else if (state_q == StRunBurst) begin
                  if (remaining_q == VAL_WIDTH'(1)) begin
                     burst_done_d = 1'b1;
                     state_d      = StIdle;
                  end else begin
                     remaining_d = remaining_q - VAL_WIDTH'(1);
                  end
               end
            end
            StStopping: begin
               state_d      = StIdle;
               pend_valid_d = 1'b0;
            end
            default: ;
         endcase
      end

      if (bus.cmd_valid) begin
         case (state_d)
            StIdle: begin
               case (op)
                  OpStart: begin
                     if (val == '0) begin
                        cmd_error_d = 1'b1;
                     end else begin
                        count_d      = new_count;
                        frames_d     = '0;
                        pend_valid_d = 1'b0;
                        state_d      = StRunCont;
                     end
                  end
                  OpSingle: begin
                     if (val == '0) begin
                        cmd_error_d = 1'b1;
                     end else begin
                        remaining_d = val;
                        frames_d    = '0;
                        state_d     = StRunBurst;
                     end
                  end
                  default: ;
               endcase
            end
            StRunCont, StRunBurst: begin
               case (op)
                  OpStart: begin
                     if (val == '0) begin
                        cmd_error_d = 1'b1;
                     end else begin
                        pend_d       = new_count;
                        pend_valid_d = 1'b1;
                     end
                  end
                  OpStop:   state_d     = StStopping;
                  OpSingle: cmd_error_d = 1'b1;
                  default: ;
               endcase
            end
            default: cmd_error_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         count_q      <= COUNT_WIDTH'(DEFAULT_INTG);
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         remaining_q  <= '0;
         frames_q     <= '0;
         burst_done_q <= 1'b0;
         cmd_error_q  <= 1'b0;
         running_q    <= 1'b0;
         cmd_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         remaining_q  <= remaining_d;
         frames_q     <= frames_d;
         burst_done_q <= burst_done_d;
         cmd_error_q  <= cmd_error_d;
         running_q    <= (state_d != StIdle);
         cmd_ready_q  <= (state_d != StStopping);
      end
   end

   assign bus.running                 = running_q;
   assign bus.cmd_ready               = cmd_ready_q;
   assign bus.integration_clock_count = count_q;
   assign bus.frame_count             = frames_q;
   assign bus.burst_done              = burst_done_q;
   assign bus.cmd_error               = cmd_error_q;
endmodule
